// File: rtl/apb_splitter_timeout_pkg.sv
// Shared APB fabric definitions: splitter state encoding and sizing helpers.
package apb_splitter_timeout_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_MISS   = 2'd2
    } state_t;

    // Bits needed to encode n indices, never less than one.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/apb_splitter_timeout_addr_decode.sv
// Combinational APB address decoder: mask/compare per slave, lowest index wins.
module apb_addr_decode #(
    parameter int                           N_SLAVES  = 2,
    parameter int                           W_ADDR    = 16,
    parameter int                           W_SEL     = 1,
    parameter logic [N_SLAVES*W_ADDR-1:0]   ADDR_MAP  = {16'h1000, 16'h0000},
    parameter logic [N_SLAVES*W_ADDR-1:0]   ADDR_MASK = {16'hf000, 16'hf000}
) (
    input  logic [W_ADDR-1:0]   paddr,
    output logic [N_SLAVES-1:0] hit,
    output logic [W_SEL-1:0]    hit_idx,
    output logic                miss
);

    logic [N_SLAVES-1:0] raw_hit;

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_cmp
        assign raw_hit[i] = (paddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR];
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (raw_hit[i]) begin
                hit     = '0;
                hit[i]  = 1'b1;
                hit_idx = W_SEL'(i);
            end
        end
    end

    assign miss = ~|raw_hit;

endmodule

// File: rtl/apb_splitter_timeout.sv
// APB 1-to-N splitter with decode error and access-phase stall watchdog.
module apb_splitter_timeout
    import apb_splitter_timeout_pkg::*;
#(
    parameter int                           N_SLAVES       = 2,
    parameter int                           W_ADDR         = 16,
    parameter int                           W_DATA         = 32,
    parameter logic [N_SLAVES*W_ADDR-1:0]   ADDR_MAP       = {16'h1000, 16'h0000},
    parameter logic [N_SLAVES*W_ADDR-1:0]   ADDR_MASK      = {16'hf000, 16'hf000},
    parameter int                           W_TIMEOUT      = 8,
    parameter int                           TIMEOUT_CYCLES = 255,
    localparam int                          W_SEL          = clog2_min1(N_SLAVES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [W_ADDR-1:0]            apbs_paddr,
    input  logic                         apbs_psel,
    input  logic                         apbs_penable,
    input  logic                         apbs_pwrite,
    input  logic [W_DATA-1:0]            apbs_pwdata,
    output logic                         apbs_pready,
    output logic [W_DATA-1:0]            apbs_prdata,
    output logic                         apbs_pslverr,
    output logic [W_ADDR-1:0]            apbm_paddr,
    output logic [N_SLAVES-1:0]          apbm_psel,
    output logic                         apbm_penable,
    output logic                         apbm_pwrite,
    output logic [W_DATA-1:0]            apbm_pwdata,
    input  logic [N_SLAVES-1:0]          apbm_pready,
    input  logic [N_SLAVES*W_DATA-1:0]   apbm_prdata,
    input  logic [N_SLAVES-1:0]          apbm_pslverr,
    output logic                         timeout_flag,
    output logic [W_SEL-1:0]             timeout_slave,
    input  logic                         timeout_clr
);

    if (TIMEOUT_CYCLES < 0 ||
        longint'(TIMEOUT_CYCLES) > ((longint'(1) << W_TIMEOUT) - 1)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES does not fit in a W_TIMEOUT-bit counter");
    end

    state_t                state, state_nxt;
    logic [W_SEL-1:0]      sel_q, sel_nxt;
    logic [W_TIMEOUT-1:0]  cnt, cnt_nxt;
    logic                  to_set;

    logic [N_SLAVES-1:0]   dec_hit;
    logic [W_SEL-1:0]      dec_idx;
    logic                  dec_miss;
    logic [W_DATA-1:0]     rdata_arr [N_SLAVES];

    wire setup  = apbs_psel && !apbs_penable;
    wire access = apbs_psel && apbs_penable;
    wire wd_hit = (TIMEOUT_CYCLES != 0) && (cnt == W_TIMEOUT'(TIMEOUT_CYCLES));

    apb_addr_decode #(
        .N_SLAVES  (N_SLAVES),
        .W_ADDR    (W_ADDR),
        .W_SEL     (W_SEL),
        .ADDR_MAP  (ADDR_MAP),
        .ADDR_MASK (ADDR_MASK)
    ) u_dec (
        .paddr   (apbs_paddr),
        .hit     (dec_hit),
        .hit_idx (dec_idx),
        .miss    (dec_miss)
    );

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_rdata
        assign rdata_arr[i] = apbm_prdata[i*W_DATA +: W_DATA];
    end

    // Broadcast side of the bus is a pure pass-through: zero added latency.
    assign apbm_paddr   = apbs_paddr;
    assign apbm_penable = apbs_penable;
    assign apbm_pwrite  = apbs_pwrite;
    assign apbm_pwdata  = apbs_pwdata;

    // State, selected slave and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sel_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sel_q <= sel_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and upstream/downstream handshake. A setup phase restarts
    // the FSM from any state so back-to-back transfers need no idle gap.
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel_q;
        cnt_nxt      = cnt;
        to_set       = 1'b0;
        apbm_psel    = '0;
        apbs_pready  = 1'b0;
        apbs_prdata  = '0;
        apbs_pslverr = 1'b0;
        if (setup) begin
            apbm_psel = dec_hit;
            sel_nxt   = dec_idx;
            cnt_nxt   = '0;
            state_nxt = dec_miss ? S_MISS : S_ACCESS;
        end else if (access) begin
            case (state)
                S_ACCESS: begin
                    if (wd_hit) begin
                        // Abort wins over whatever the slave says this cycle.
                        apbs_pready  = 1'b1;
                        apbs_pslverr = 1'b1;
                        to_set       = 1'b1;
                        state_nxt    = S_IDLE;
                    end else begin
                        apbm_psel[sel_q] = 1'b1;
                        apbs_pready      = apbm_pready[sel_q];
                        apbs_prdata      = rdata_arr[sel_q];
                        apbs_pslverr     = apbm_pslverr[sel_q];
                        if (apbm_pready[sel_q])
                            state_nxt = S_IDLE;
                        else if (cnt != {W_TIMEOUT{1'b1}})
                            cnt_nxt = cnt + 1'b1;
                    end
                end
                S_MISS: begin
                    apbs_pready  = 1'b1;
                    apbs_pslverr = 1'b1;
                    state_nxt    = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else begin
            // Upstream dropped psel (or is idle): abandon quietly.
            state_nxt = S_IDLE;
        end
    end

    // Sticky watchdog status; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_flag  <= 1'b0;
            timeout_slave <= '0;
        end else if (to_set) begin
            timeout_flag  <= 1'b1;
            timeout_slave <= sel_q;
        end else if (timeout_clr) begin
            timeout_flag  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_splitter_timeout.sv
// Directed bench for apb_splitter_timeout (2 slaves, watchdog limit 4).
module tb_apb_splitter_timeout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] apbs_paddr = '0;
    logic        apbs_psel = 1'b0, apbs_penable = 1'b0, apbs_pwrite = 1'b0;
    logic [31:0] apbs_pwdata = '0;
    logic        apbs_pready, apbs_pslverr;
    logic [31:0] apbs_prdata;
    logic [15:0] apbm_paddr;
    logic [1:0]  apbm_psel;
    logic        apbm_penable, apbm_pwrite;
    logic [31:0] apbm_pwdata;
    logic [1:0]  apbm_pready = '0, apbm_pslverr = '0;
    logic [31:0] s0_rdata = '0, s1_rdata = '0;
    logic        timeout_flag, timeout_slave;
    logic        timeout_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_splitter_timeout #(.N_SLAVES(2), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .apbs_paddr(apbs_paddr), .apbs_psel(apbs_psel), .apbs_penable(apbs_penable),
        .apbs_pwrite(apbs_pwrite), .apbs_pwdata(apbs_pwdata),
        .apbs_pready(apbs_pready), .apbs_prdata(apbs_prdata), .apbs_pslverr(apbs_pslverr),
        .apbm_paddr(apbm_paddr), .apbm_psel(apbm_psel), .apbm_penable(apbm_penable),
        .apbm_pwrite(apbm_pwrite), .apbm_pwdata(apbm_pwdata),
        .apbm_pready(apbm_pready), .apbm_prdata({s1_rdata, s0_rdata}), .apbm_pslverr(apbm_pslverr),
        .timeout_flag(timeout_flag), .timeout_slave(timeout_slave), .timeout_clr(timeout_clr)
    );

    // Advance one cycle; inputs change and outputs are sampled 1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", timeout_flag); end
        checks++; if (timeout_slave !== 1'b0) begin failures++; $display("FAIL reset_slave got=%b exp=0", timeout_slave); end
        checks++; if ({apbm_psel, apbs_pready, apbs_pslverr} !== 4'b0000) begin failures++; $display("FAIL reset_outs got=%b exp=0000", {apbm_psel, apbs_pready, apbs_pslverr}); end
        checks++; if (apbs_prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", apbs_prdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_hit();
        apbm_pready = 2'b10; s1_rdata = 32'hCAFEF00D; s0_rdata = 32'h11111111;
        apbs_paddr = 16'h1004; apbs_pwrite = 1'b0; apbs_psel = 1'b1; apbs_penable = 1'b0;
        #1;
        checks++; if (apbm_psel !== 2'b10) begin failures++; $display("FAIL rd_setup_psel got=%b exp=10", apbm_psel); end
        checks++; if (apbs_pready !== 1'b0) begin failures++; $display("FAIL rd_setup_ready got=%b exp=0", apbs_pready); end
        tick(); apbs_penable = 1'b1; #1;
        checks++; if (apbm_psel !== 2'b10) begin failures++; $display("FAIL rd_acc_psel got=%b exp=10", apbm_psel); end
        checks++; if ({apbs_pready, apbs_pslverr} !== 2'b10) begin failures++; $display("FAIL rd_acc_resp got=%b exp=10", {apbs_pready, apbs_pslverr}); end
        checks++; if (apbs_prdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rd_acc_data got=%h exp=cafef00d", apbs_prdata); end
        checks++; if (apbm_penable !== 1'b1 || apbm_paddr !== 16'h1004) begin failures++; $display("FAIL rd_bcast got=%b/%h exp=1/1004", apbm_penable, apbm_paddr); end
        tick(); apbs_psel = 1'b0; apbs_penable = 1'b0; #1;
        checks++; if ({apbm_psel, apbs_pready} !== 3'b000) begin failures++; $display("FAIL rd_idle got=%b exp=000", {apbm_psel, apbs_pready}); end
        tick();
    endtask

    task automatic test_write_stall();
        apbm_pready = 2'b00;
        apbs_paddr = 16'h0010; apbs_pwrite = 1'b1; apbs_pwdata = 32'h12345678;
        apbs_psel = 1'b1; apbs_penable = 1'b0; #1;
        checks++; if (apbm_psel !== 2'b01) begin failures++; $display("FAIL wr_setup_psel got=%b exp=01", apbm_psel); end
        tick(); apbs_penable = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (apbs_pready !== 1'b0 || apbm_psel !== 2'b01) begin failures++; $display("FAIL wr_stall%0d got=%b/%b exp=0/01", c, apbs_pready, apbm_psel); end
            checks++; if (apbm_pwdata !== 32'h12345678 || apbm_pwrite !== 1'b1) begin failures++; $display("FAIL wr_data%0d got=%h exp=12345678", c, apbm_pwdata); end
            tick();
        end
        apbm_pready = 2'b01; #1;
        checks++; if ({apbs_pready, apbs_pslverr} !== 2'b10) begin failures++; $display("FAIL wr_done got=%b exp=10", {apbs_pready, apbs_pslverr}); end
        tick(); apbs_psel = 1'b0; apbs_penable = 1'b0; apbs_pwrite = 1'b0; #1;
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL wr_noflag got=%b exp=0", timeout_flag); end
        tick();
    endtask

    task automatic test_miss_back_to_back();
        apbm_pready = 2'b11; s0_rdata = 32'hAAAA0000; s1_rdata = 32'hBBBB1111;
        apbs_paddr = 16'h2000; apbs_psel = 1'b1; apbs_penable = 1'b0; #1;
        checks++; if ({apbm_psel, apbs_pready} !== 3'b000) begin failures++; $display("FAIL miss_setup got=%b exp=000", {apbm_psel, apbs_pready}); end
        tick(); apbs_penable = 1'b1; #1;
        checks++; if ({apbm_psel, apbs_pready, apbs_pslverr} !== 4'b0011) begin failures++; $display("FAIL miss_acc got=%b exp=0011", {apbm_psel, apbs_pready, apbs_pslverr}); end
        checks++; if (apbs_prdata !== 32'h0) begin failures++; $display("FAIL miss_data got=%h exp=0", apbs_prdata); end
        tick(); apbs_paddr = 16'h1000; apbs_penable = 1'b0; #1;
        checks++; if ({apbm_psel, apbs_pready} !== 3'b100) begin failures++; $display("FAIL b2b_setup got=%b exp=100", {apbm_psel, apbs_pready}); end
        tick(); apbs_penable = 1'b1; #1;
        checks++; if ({apbs_pready, apbs_pslverr} !== 2'b10 || apbs_prdata !== 32'hBBBB1111) begin failures++; $display("FAIL b2b_acc got=%b/%h exp=10/bbbb1111", {apbs_pready, apbs_pslverr}, apbs_prdata); end
        tick(); apbs_psel = 1'b0; apbs_penable = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        apbm_pready = 2'b00; s1_rdata = 32'h0;
        apbs_paddr = 16'h1008; apbs_psel = 1'b1; apbs_penable = 1'b0;
        tick(); apbs_penable = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++; if (apbs_pready !== 1'b0 || apbm_psel !== 2'b10) begin failures++; $display("FAIL to_stall%0d got=%b/%b exp=0/10", c, apbs_pready, apbm_psel); end
            tick();
        end
        // Slave answers just as the watchdog fires; the abort must win.
        apbm_pready = 2'b10; s1_rdata = 32'hDEADBEEF; #1;
        checks++; if ({apbm_psel, apbs_pready, apbs_pslverr} !== 4'b0011) begin failures++; $display("FAIL to_abort got=%b exp=0011", {apbm_psel, apbs_pready, apbs_pslverr}); end
        checks++; if (apbs_prdata !== 32'h0) begin failures++; $display("FAIL to_abort_data got=%h exp=0", apbs_prdata); end
        tick(); apbs_psel = 1'b0; apbs_penable = 1'b0; #1;
        checks++; if ({timeout_flag, timeout_slave} !== 2'b11) begin failures++; $display("FAIL to_status got=%b exp=11", {timeout_flag, timeout_slave}); end
        tick();
        apbm_pready = 2'b01; apbs_paddr = 16'h0004; apbs_psel = 1'b1;
        tick(); apbs_penable = 1'b1; #1;
        checks++; if ({apbs_pready, apbs_pslverr} !== 2'b10) begin failures++; $display("FAIL to_good got=%b exp=10", {apbs_pready, apbs_pslverr}); end
        tick(); apbs_psel = 1'b0; apbs_penable = 1'b0; #1;
        checks++; if ({timeout_flag, timeout_slave} !== 2'b11) begin failures++; $display("FAIL to_sticky got=%b exp=11", {timeout_flag, timeout_slave}); end
        tick();
    endtask

    task automatic test_clear();
        apbm_pready = 2'b00;
        apbs_paddr = 16'h0000; apbs_psel = 1'b1; apbs_penable = 1'b0;
        tick(); apbs_penable = 1'b1;
        for (int c = 1; c <= 4; c++) tick();
        timeout_clr = 1'b1; #1;
        checks++; if ({apbs_pready, apbs_pslverr} !== 2'b11) begin failures++; $display("FAIL clr_abort got=%b exp=11", {apbs_pready, apbs_pslverr}); end
        tick(); timeout_clr = 1'b0; apbs_psel = 1'b0; apbs_penable = 1'b0; #1;
        checks++; if ({timeout_flag, timeout_slave} !== 2'b10) begin failures++; $display("FAIL clr_setwins got=%b exp=10", {timeout_flag, timeout_slave}); end
        tick(); timeout_clr = 1'b1;
        tick(); timeout_clr = 1'b0; #1;
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL clr_lone got=%b exp=0", timeout_flag); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        // Arm the status first so the reset has something to clear.
        apbm_pready = 2'b00;
        apbs_paddr = 16'h1000; apbs_psel = 1'b1; apbs_penable = 1'b0;
        tick(); apbs_penable = 1'b1;
        for (int c = 1; c <= 5; c++) tick();
        apbs_psel = 1'b0; apbs_penable = 1'b0; #1;
        checks++; if ({timeout_flag, timeout_slave} !== 2'b11) begin failures++; $display("FAIL rst_pre got=%b exp=11", {timeout_flag, timeout_slave}); end
        tick(); apbs_psel = 1'b1;
        tick(); apbs_penable = 1'b1;
        tick(); rst = 1'b1; apbs_psel = 1'b0; apbs_penable = 1'b0;
        tick(); rst = 1'b0; #1;
        checks++; if ({timeout_flag, timeout_slave} !== 2'b00) begin failures++; $display("FAIL rst_status got=%b exp=00", {timeout_flag, timeout_slave}); end
        checks++; if ({apbm_psel, apbs_pready} !== 3'b000) begin failures++; $display("FAIL rst_outs got=%b exp=000", {apbm_psel, apbs_pready}); end
        tick();
        apbm_pready = 2'b01; s0_rdata = 32'h5A5A0001;
        apbs_paddr = 16'h0000; apbs_psel = 1'b1; #1;
        checks++; if (apbm_psel !== 2'b01) begin failures++; $display("FAIL rst_fresh_setup got=%b exp=01", apbm_psel); end
        tick(); apbs_penable = 1'b1; #1;
        checks++; if ({apbs_pready, apbs_pslverr} !== 2'b10 || apbs_prdata !== 32'h5A5A0001) begin failures++; $display("FAIL rst_fresh_acc got=%b/%h exp=10/5a5a0001", {apbs_pready, apbs_pslverr}, apbs_prdata); end
        tick(); apbs_psel = 1'b0; apbs_penable = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=hung exp=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        test_reset();
        test_read_hit();
        test_write_stall();
        test_miss_back_to_back();
        test_timeout();
        test_clear();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_splitter_timeout.md
Name: apb_splitter_timeout

Overview:
- APB fabric stage sitting directly downstream of the AHB-Lite-to-APB bridge: one APB slave port in, N APB master ports out.
- Decodes each transfer's address to one downstream slave and forwards the transfer with zero added latency.
- Returns a decode error on unmapped addresses.
- A stall watchdog aborts any access phase that exceeds a cycle budget and returns PSLVERR upstream, so a hung peripheral cannot lock the AHB bus.
- Logs the watchdog event in a sticky status register.

Parameters:
- N_SLAVES, 2, number of downstream APB ports (≥1).
- W_ADDR, 16, APB address width.
- W_DATA, 32, APB data width.
- ADDR_MAP, {16'h1000, 16'h0000}, packed N_SLAVES×W_ADDR base addresses, slave i at bits [i*W_ADDR +: W_ADDR].
- ADDR_MASK, {16'hf000, 16'hf000}, packed N_SLAVES×W_ADDR decode masks, same layout.
- W_TIMEOUT, 8, watchdog counter width.
- TIMEOUT_CYCLES, 255, maximum stalled access cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- apbs_paddr  in  W_ADDR  upstream address
- apbs_psel  in  1  upstream select
- apbs_penable  in  1  upstream enable
- apbs_pwrite  in  1  upstream write
- apbs_pwdata  in  W_DATA  upstream write data
- apbs_pready  out  1  upstream ready
- apbs_prdata  out  W_DATA  upstream read data
- apbs_pslverr  out  1  upstream error
- apbm_paddr  out  W_ADDR  broadcast address
- apbm_psel  out  N_SLAVES  one-hot select
- apbm_penable  out  1  broadcast enable
- apbm_pwrite  out  1  broadcast write
- apbm_pwdata  out  W_DATA  broadcast write data
- apbm_pready  in  N_SLAVES  per-slave ready
- apbm_prdata  in  N_SLAVES*W_DATA  per-slave read data, packed
- apbm_pslverr  in  N_SLAVES  per-slave error
- timeout_flag  out  1  sticky watchdog-fired flag
- timeout_slave  out  W_SEL  index of the slave that timed out; W_SEL = max(1, clog2(N_SLAVES))
- timeout_clr  in  1  clears timeout_flag

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All flops reset synchronously.
- Reset values:
  - state=S_IDLE, sel_q=0, cnt=0, timeout_flag=0, timeout_slave=0.
  - Outputs are combinational from state and inputs, so apbm_psel=0 and apbs_pready=0 while upstream psel=0.
- Decode: slave i hits when (apbs_paddr & ADDR_MASK[i]) == ADDR_MAP[i]. On a multi-hit, the lowest index wins.
- Broadcast outputs: apbm_paddr, apbm_pwrite, apbm_pwdata and apbm_penable pass straight through from upstream.
- States (2-bit):
  - S_IDLE: no transfer.
  - S_ACCESS: forwarding to slave sel_q.
  - S_MISS: decode error.
- Setup cycle (apbs_psel && !apbs_penable, any state):
  - apbm_psel = one-hot of the combinational hit, or 0 on a miss.
  - sel_q <= hit index; cnt <= 0.
  - Next state is S_ACCESS on a hit, S_MISS on a miss.
  - apbs_pready=0.
- S_ACCESS, while apbs_psel && apbs_penable:
  - apbm_psel[sel_q]=1.
  - apbs_pready/prdata/pslverr = slave sel_q's pready/prdata/pslverr.
  - Slave pready=1 ends the transfer: next state S_IDLE.
  - Slave pready=0: cnt <= cnt+1, saturating at all-ones.
- Watchdog, in S_ACCESS with TIMEOUT_CYCLES≠0 and cnt == TIMEOUT_CYCLES:
  - Drives apbs_pready=1, apbs_pslverr=1, apbs_prdata=0, and forces apbm_psel=0 that cycle.
  - timeout_flag <= 1; timeout_slave <= sel_q; next state S_IDLE.
  - The abort fires on access cycle TIMEOUT_CYCLES+1 and overrides any slave response in the same cycle.
- S_MISS: apbs_pready=1, apbs_pslverr=1, apbs_prdata=0, apbm_psel=0; next state S_IDLE. Single-cycle access phase.
- Outside access phases: apbs_prdata=0 and apbs_pslverr=0.
- timeout_clr:
  - Clears timeout_flag.
  - If clear and a new timeout occur in the same cycle, set wins and timeout_slave updates.
  - A repeated timeout overwrites timeout_slave.
- Protocol violations:
  - Upstream psel dropping mid-access returns the state to S_IDLE the next cycle, with no flag.
  - Back-to-back transfers need no idle cycle: a setup phase in the cycle after completion is accepted normally.
- Reset mid-transfer: state returns to S_IDLE. The downstream slave sees psel drop only because upstream psel drops; this block does not hold it.
- Static requirement: TIMEOUT_CYCLES ≤ 2^W_TIMEOUT−1; elaboration error otherwise.

Decomposition:
- Shared fabric package holds:
  - the state encodings (S_IDLE/S_ACCESS/S_MISS);
  - a clog2 helper function for W_SEL.
- One natural sub-module: apb_addr_decode. It is purely combinational: paddr, ADDR_MAP, ADDR_MASK in; one-hot hit, encoded index and miss flag out. It is reused by future APB/AHB splitters.
- Counter, state register and status register stay in the top module.

Test Plan:
- Read 0x1004 with N_SLAVES=2 and default map; slave1 pready=1 on the first access cycle, prdata=0xCAFEF00D → apbm_psel=2'b10 in setup and access; upstream completes in 2 cycles with prdata=0xCAFEF00D, pslverr=0.
- Write 0x0010 data 0x12345678; slave0 stalls 3 cycles → apbm_pwdata=0x12345678 held; apbs_pready=1 on access cycle 4; cnt never reaches the limit; timeout_flag stays 0.
- Read 0x2000 (unmapped) → apbm_psel=0 throughout; apbs_pready=1, pslverr=1, prdata=0 on the first access cycle; next transfer accepted the following cycle.
- TIMEOUT_CYCLES=4; slave1 never asserts pready → abort on access cycle 5 with pready=1, pslverr=1, apbm_psel=0; timeout_flag=1 and timeout_slave=1 the next cycle; the flag survives subsequent good transfers.
- timeout_clr pulsed in the same cycle as a new timeout on slave0 → flag stays 1 and timeout_slave=0. A later lone clr pulse → flag 0.
- Assert rst mid-stall (access cycle 2) with upstream psel dropped → state S_IDLE; all status 0; a fresh read to 0x0000 completes normally.
